// File: rtl/prep1_param_if.sv
// Bus bundle for prep1_param: mux/shift controls in, shift register state out.
// PREP1_PARAM_SERIAL_IN_EN adds the serial input sin.
interface prep1_param_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    en;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] d;
  logic [1:0]              mode;
`ifdef PREP1_PARAM_SERIAL_IN_EN
  logic                    sin;
`endif
  logic [WIDTH-1:0]        q;
  logic [$clog2(WIDTH):0]  rot_cnt;
  logic                    wrap;

`ifdef PREP1_PARAM_SERIAL_IN_EN
  modport master (output en, sel, d, mode, sin, input q, rot_cnt, wrap);
  modport slave  (input en, sel, d, mode, sin, output q, rot_cnt, wrap);
`else
  modport master (output en, sel, d, mode, input q, rot_cnt, wrap);
  modport slave  (input en, sel, d, mode, output q, rot_cnt, wrap);
`endif
endinterface

// File: rtl/prep1_param.sv
// Parameterised mux -> pipeline register -> rotate/shift register with rotation counter.
// PREP1_PARAM_SERIAL_IN_EN turns rotates into shifts fed from bus.sin.
module prep1_param #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic           clk,
  input logic           rst_n,
  prep1_param_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_ROTL = 2'b01,
    MODE_ROTR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;
  logic             wrap_nxt;
  logic             fill_l;
  logic             fill_r;
  mode_t            mode;

  assign mode = mode_t'(bus.mode);

  // Unmatched select values (sel >= NUM_IN) fall through to zero.
  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) y = bus.d[k*WIDTH +: WIDTH];
    end
  end

`ifdef PREP1_PARAM_SERIAL_IN_EN
  assign fill_l = bus.sin;
  assign fill_r = bus.sin;
`else
  assign fill_l = q[WIDTH-1];
  assign fill_r = q[0];
`endif

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    case (mode)
      MODE_LOAD: begin
        q_nxt   = q_reg;
        cnt_nxt = '0;
      end
      MODE_ROTL: begin
        q_nxt = {q[WIDTH-2:0], fill_l};
        if (cnt == CNT_MAX) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      MODE_ROTR: begin
        q_nxt = {fill_r, q[WIDTH-1:1]};
        if (cnt == '0) begin
          cnt_nxt  = CNT_MAX;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        q_nxt = q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      q     <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else if (bus.en) begin
      q_reg <= y;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign bus.q       = q;
  assign bus.rot_cnt = cnt;
  assign bus.wrap    = wrap;
endmodule

// File: doc/prep1_param.md
PREP1_PARAM -- requirements
Module: prep1_param

Interface
REQ-001 Parameter WIDTH, default 8: data width of every channel, the register and the shift register; legal range 2..32.
REQ-002 Parameter NUM_IN, default 4: number of mux input channels; legal range 2..16.
REQ-003 Parameter SEL_W, default 2: select width, which SHALL equal ceil(log2(NUM_IN)).
REQ-004 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port RST_N, input, 1: asynchronous, active-low reset.
REQ-006 Port EN, input, 1: global enable; when low, all state holds.
REQ-007 Port SEL, input, SEL_W: mux channel select.
REQ-008 Port D, input, NUM_IN*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port MODE, input, 2: 00 load, 01 rotate left, 10 rotate right, 11 hold.
REQ-010 Port Q, output, WIDTH: shift register contents (registered).
REQ-011 Port ROT_CNT, output, clog2(WIDTH)+1: number of rotations since the last load (registered).
REQ-012 Port WRAP, output, 1: single-cycle registered pulse when the net rotation reaches a full WIDTH turn.

Function
REQ-013 Mux Y is combinational: Y = channel SEL when SEL < NUM_IN; otherwise Y = 0.
REQ-014 Pipeline register q_reg SHALL load Y on every CLK edge with EN=1, in every MODE.
REQ-015 MODE=00 with EN=1: Q <= the old q_reg, ROT_CNT <= 0, WRAP <= 0; D-to-Q latency is 2 enabled cycles.
REQ-016 MODE=01 with EN=1: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; ROT_CNT increments.
REQ-017 MODE=10 with EN=1: Q <= {Q[0], Q[WIDTH-1:1]}; ROT_CNT decrements.
REQ-018 MODE=11 with EN=1: Q and ROT_CNT hold; q_reg still loads; WRAP <= 0.
REQ-019 ROT_CNT is a modular up/down counter over 0..WIDTH-1: increment from WIDTH-1 gives 0; decrement from 0 gives WIDTH-1.
REQ-020 WRAP SHALL be 1 in the cycle after ROT_CNT transitions WIDTH-1 -> 0 by increment or 0 -> WIDTH-1 by decrement; otherwise 0.
REQ-021 EN=0: q_reg, Q and ROT_CNT hold; WRAP <= 0.
REQ-022 A MODE change between consecutive cycles takes effect immediately and needs no idle cycle.

Reset
REQ-023 RST_N low SHALL immediately force q_reg=0, Q=0, ROT_CNT=0 and WRAP=0, independent of CLK.
REQ-024 Reset asserted mid-rotation SHALL discard all state; the first enabled edge after release behaves as from the reset values.
REQ-025 Reset release is assumed synchronous to CLK externally; the block adds no reset synchroniser.

Configuration
REQ-026 Macro PREP1_PARAM_SERIAL_IN_EN, when defined, adds input port SIN (1 bit) after MODE.
REQ-027 With the macro defined, modes 01 and 10 become shifts, not rotates: mode 01 gives Q <= {Q[WIDTH-2:0], SIN}, mode 10 gives Q <= {SIN, Q[WIDTH-1:1]}; ROT_CNT and WRAP behave unchanged.
REQ-028 Without the macro, SIN does not exist and REQ-016/REQ-017 rotate behaviour applies.

Verification
REQ-029 Reset with defaults: RST_N=0 mid-clock -> Q=0x00, ROT_CNT=0 and WRAP=0 before the next edge; then EN=1, MODE=00, SEL=2, D ch2=0xA5 for 2 edges -> Q=0xA5 after the second edge.
REQ-030 Rotate and wrap: Q=0x81, then MODE=01 for 8 edges -> Q sequence 0x03, 0x06, 0x0C, 0x18, 0x30, 0x60, 0xC0, 0x81; ROT_CNT reaches 0 on edge 8; WRAP=1 for exactly one cycle after edge 8.
REQ-031 Right-rotate underflow: after load (ROT_CNT=0) with Q=0x01, MODE=10 for 1 edge -> Q=0x80, ROT_CNT=7, WRAP=1 for one cycle.
REQ-032 Enable/hold: EN=0 with MODE=01 for 3 edges -> Q, q_reg and ROT_CNT unchanged; MODE=11 with EN=1 and SEL changing -> Q unchanged; a following MODE=00 loads the last selected channel.
REQ-033 Parametrisation: WIDTH=12, NUM_IN=5, SEL_W=3; SEL=6 then MODE=00 twice -> Q=0x000; SEL=4 with D ch4=0xABC -> Q=0xABC.
REQ-034 Macro build: PREP1_PARAM_SERIAL_IN_EN defined, Q=0x00, SIN=1, MODE=01 for 3 edges -> Q=0x07; then MODE=10 with SIN=0 for 1 edge -> Q=0x03.
